// File: rtl/spi_pkg.sv
// Shared constants, FSM encoding and frame-layout helper for the SPI ADC responder.
// Frame = lead zeros followed by the DATA_BITS sample, MSB first.
package spi_pkg;

  localparam int FRAME_BITS  = 16;
  localparam int DATA_BITS   = 12;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int lead_zeros();
    return FRAME_BITS - DATA_BITS;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin with rise/fall pulses on the
// synchronised value; pulses are combinational, one clk wide.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q <= {STAGES{RST_VAL}};
      prev_q  <= RST_VAL;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = chain_q[STAGES-1] & ~prev_q;
  assign fall_o = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI mode-0 responder standing in for the 12-bit ADC: serves {lead zeros, sample}
// on MISO and captures the MOSI frame; SPI pins are oversampled on clk.
module spi_adc_responder
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  miso_oe,
  input  logic [DATA_BITS-1:0]  sample_in,
  input  logic                  sample_load,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int               LEAD      = lead_zeros();
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

  logic sck_sync, sck_rise, sck_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_sync;

  logic [SYNC_STAGES-1:0] mosi_q;
  logic [SYNC_STAGES-1:0] flush_q;
  logic                   armed_q, armed_d;

  state_e                 state_q, state_d;
  logic [FRAME_BITS-1:0]  tx_sh_q, tx_sh_d;
  logic [FRAME_BITS-1:0]  rx_sh_q, rx_sh_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   overrun_q, overrun_d;
  logic [DATA_BITS-1:0]   hold_q, hold_d;
  logic [FRAME_BITS-1:0]  rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (SCK),
    .sync_o (sck_sync),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (CS),
    .sync_o (cs_sync),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // MOSI goes through the same depth as SCK so the sampled bit lines up with the rise pulse.
  assign mosi_sync = mosi_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mosi_q      <= '0;
      flush_q     <= '0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      bit_cnt_q   <= '0;
      overrun_q   <= 1'b0;
      hold_q      <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      mosi_q      <= {mosi_q[SYNC_STAGES-2:0], MOSI};
      flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
      armed_q     <= armed_d;
      state_q     <= state_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      bit_cnt_q   <= bit_cnt_d;
      overrun_q   <= overrun_d;
      hold_q      <= hold_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    bit_cnt_d   = bit_cnt_q;
    overrun_d   = overrun_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    hold_d      = sample_load ? sample_in : hold_q;
    // The CS chain resets high, so only a high seen after the chain has flushed arms a start.
    armed_d     = armed_q | (flush_q[SYNC_STAGES-1] & cs_sync);

    case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          state_d   = SHIFT;
          tx_sh_d   = {{LEAD{1'b0}}, hold_d};
          bit_cnt_d = '0;
          overrun_d = 1'b0;
        end
      end
      SHIFT, DONE: begin
        if (cs_rise) begin
          state_d = IDLE;
          tx_sh_d = '0;
          if (bit_cnt_q == FRAME_CNT && !overrun_q) begin
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (state_q == SHIFT) begin
          if (sck_rise) begin
            rx_sh_d   = {rx_sh_q[FRAME_BITS-2:0], mosi_sync};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_d == FRAME_CNT) begin
              state_d = DONE;
              tx_sh_d = '0;
            end
          end else if (sck_fall) begin
            tx_sh_d = {tx_sh_q[FRAME_BITS-2:0], 1'b0};
          end
        end else if (sck_rise) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // MISO is the shifter MSB directly, so it is zero whenever the shifter is cleared.
  assign MISO      = tx_sh_q[FRAME_BITS-1];
  assign miso_oe   = (state_q != IDLE);
  assign busy      = (state_q != IDLE);
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

  logic unused_ok;
  assign unused_ok = sck_sync;

endmodule
